// File: rtl/band_update_scheduler.sv
// Band update scheduler: requests band powers 0..NUM_BINS-1 from the shared
// calculator on every prescaled sample tick, collects them in a shadow bank,
// and commits the full set to the display bank at a frame boundary.
module band_update_scheduler #(
  parameter int unsigned NUM_BINS = 10,
  parameter int unsigned VAL_W    = 12,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                      vga_clk,
  input  logic                      rst_n,
  input  logic                      sample_tick,
  input  logic [CNT_W-1:0]          prescaler,
  input  logic                      frame_start,
  output logic                      calc_start,
  output logic [3:0]                calc_band,
  input  logic                      calc_done,
  input  logic [VAL_W-1:0]          calc_value,
  output logic [NUM_BINS*VAL_W-1:0] bins_out,
  output logic                      commit_pulse,
  output logic                      busy,
  output logic                      overrun,
  output logic                      timeout_err
);

  localparam int unsigned       WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [3:0]        LAST_IDX  = 4'(NUM_BINS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PEND
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [3:0]                  idx_q, idx_d;
  logic [WAIT_W-1:0]           wait_q, wait_d;
  logic [VAL_W-1:0]            shadow_q [NUM_BINS];
  logic [VAL_W-1:0]            shadow_d [NUM_BINS];
  logic [NUM_BINS*VAL_W-1:0]   bins_q, bins_d;
  logic                        commit_q, commit_d;
  logic                        busy_q, busy_d;
  logic                        overrun_q, overrun_d;
  logic                        tout_q, tout_d;
  logic                        trigger;

  // Request strobe and band index come straight from the registered state.
  assign calc_start   = (state_q == S_REQ);
  assign calc_band    = idx_q;
  assign bins_out     = bins_q;
  assign commit_pulse = commit_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign timeout_err  = tout_q;

  // Next-state: prescaler counter, sequencing FSM, shadow/display banks.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    shadow_d  = shadow_q;
    bins_d    = bins_q;
    commit_d  = 1'b0;
    overrun_d = overrun_q;
    tout_d    = tout_q;
    trigger   = 1'b0;

    // Counter runs regardless of FSM state; >= lets a live prescaler decrease
    // below the current count fire on the very next tick.
    if (sample_tick) begin
      if (cnt_q >= prescaler) begin
        cnt_d   = '0;
        trigger = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (trigger && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          idx_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (calc_done || (wait_q == WAIT_LAST)) begin
          for (int unsigned k = 0; k < NUM_BINS; k++) begin
            if (idx_q == 4'(k)) begin
              shadow_d[k] = calc_done ? calc_value : '0;
            end
          end
          if (!calc_done) begin
            tout_d = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_PEND;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_REQ;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_PEND: begin
        if (frame_start) begin
          for (int unsigned k = 0; k < NUM_BINS; k++) begin
            bins_d[k*VAL_W +: VAL_W] = shadow_q[k];
          end
          commit_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and bank registers with synchronous active-low reset.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wait_q    <= '0;
      for (int unsigned k = 0; k < NUM_BINS; k++) begin
        shadow_q[k] <= '0;
      end
      bins_q    <= '0;
      commit_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      shadow_q  <= shadow_d;
      bins_q    <= bins_d;
      commit_q  <= commit_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      tout_q    <= tout_d;
    end
  end

endmodule

// File: tb/tb_band_update_scheduler.sv
// Scoreboard bench for band_update_scheduler: expected request bands and
// committed banks are queued by the stimulus and checked by a monitor.
module tb_band_update_scheduler;

  localparam int NB = 10;
  localparam int VW = 12;
  localparam int CW = 16;
  localparam int BW = NB * VW;

  logic          vga_clk = 1'b0;
  logic          rst_n, sample_tick, frame_start, calc_done;
  logic [CW-1:0] prescaler;
  logic [VW-1:0] calc_value;
  logic          calc_start, commit_pulse, busy, overrun, timeout_err;
  logic [3:0]    calc_band;
  logic [BW-1:0] bins_out;

  band_update_scheduler #(
    .NUM_BINS(NB),
    .VAL_W   (VW),
    .CNT_W   (CW),
    .TIMEOUT (8)
  ) dut (
    .vga_clk     (vga_clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .prescaler   (prescaler),
    .frame_start (frame_start),
    .calc_start  (calc_start),
    .calc_band   (calc_band),
    .calc_done   (calc_done),
    .calc_value  (calc_value),
    .bins_out    (bins_out),
    .commit_pulse(commit_pulse),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 vga_clk = ~vga_clk;

  int cyc_n = 0;
  always @(posedge vga_clk) cyc_n <= cyc_n + 1;

  int n_tot  = 0;
  int n_pass = 0;
  int trig_cyc = 0;
  int start_cyc [16];
  int exp_band_q [$];
  logic [BW-1:0] exp_bins_q [$];

  // calculator model controls
  int calc_lat  = 1;
  int skip_band = -1;
  int voff      = 0;

  function automatic void chk(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
  endfunction

  function automatic logic [BW-1:0] mk_bins(int off, int zb);
    logic [BW-1:0] v;
    v = '0;
    for (int b = 0; b < NB; b++)
      if (b != zb) v[b*VW +: VW] = VW'(b * 100 + 1 + off);
    return v;
  endfunction

  // Calculator model: answers band*100+1+voff, calc_lat cycles after start.
  initial begin
    int b;
    calc_done  = 1'b0;
    calc_value = '0;
    forever begin
      @(negedge vga_clk);
      if (calc_start === 1'b1 && int'(calc_band) != skip_band) begin
        b = int'(calc_band);
        repeat (calc_lat) @(posedge vga_clk);
        #1;
        calc_done  = 1'b1;
        calc_value = VW'(b * 100 + 1 + voff);
        @(posedge vga_clk);
        #1;
        calc_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a request or commit.
  initial begin
    forever begin
      @(negedge vga_clk);
      if (calc_start === 1'b1) begin
        start_cyc[calc_band] = cyc_n;
        if (exp_band_q.size() == 0) chk("calc_start_unexpected", BW'(calc_start), '0);
        else chk("calc_band", BW'(calc_band), BW'(exp_band_q.pop_front()));
      end
      if (commit_pulse === 1'b1) begin
        if (exp_bins_q.size() == 0) chk("commit_unexpected", BW'(commit_pulse), '0);
        else chk("bins_out_commit", bins_out, exp_bins_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic tick();
    trig_cyc    = cyc_n;
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
  endtask

  task automatic push_seq(input int n = NB);
    for (int b = 0; b < n; b++) exp_band_q.push_back(b);
  endtask

  task automatic frame(input bit expect_commit, input logic [BW-1:0] expv);
    if (expect_commit) exp_bins_q.push_back(expv);
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    chk(expect_commit ? "commit_after_frame" : "no_commit_after_frame",
        BW'(commit_pulse), BW'(expect_commit));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    sample_tick = 1'b0;
    frame_start = 1'b0;
    prescaler   = CW'(16000);
    cyc(2);
    rst_n = 1'b1;

    // reset state
    chk("rst_busy", BW'(busy), '0);
    chk("rst_overrun", BW'(overrun), '0);
    chk("rst_timeout", BW'(timeout_err), '0);
    chk("rst_bins", bins_out, '0);
    chk("rst_calc_band", BW'(calc_band), '0);
    chk("rst_commit", BW'(commit_pulse), '0);

    // 1: prescaler=3, trigger on every 4th tick
    prescaler = CW'(3);
    push_seq();
    for (int i = 0; i < 4; i++) begin tick(); cyc(); end
    cyc(25);
    chk("t1_busy_pend", BW'(busy), BW'(1));
    chk("t1_first_start_latency", BW'(start_cyc[0]), BW'(trig_cyc + 1));
    chk("t1_band_span", BW'(start_cyc[9] - start_cyc[0]), BW'(18));
    frame(1'b1, mk_bins(0, -1));
    cyc();
    chk("t1_idle", BW'(busy), '0);
    voff = 7;
    push_seq();
    for (int i = 0; i < 4; i++) begin tick(); cyc(); end
    cyc(25);
    frame(1'b1, mk_bins(7, -1));
    voff = 0;

    // 2: frame_start mid-sequence is ignored
    do_reset();
    prescaler = CW'(0);
    push_seq();
    tick();
    cyc(5);
    frame(1'b0, '0);
    cyc(25);
    chk("t2_bins_hold", bins_out, '0);
    frame(1'b1, mk_bins(0, -1));

    // 3: band 4 never answered -> timeout after 8 WAIT cycles
    do_reset();
    skip_band = 4;
    push_seq();
    tick();
    cyc(40);
    chk("t3_timeout_err", BW'(timeout_err), BW'(1));
    chk("t3_band4_span", BW'(start_cyc[5] - start_cyc[4]), BW'(9));
    chk("t3_band3_span", BW'(start_cyc[4] - start_cyc[3]), BW'(2));
    chk("t3_no_overrun", BW'(overrun), '0);
    frame(1'b1, mk_bins(0, 4));
    cyc(3);
    chk("t3_timeout_sticky", BW'(timeout_err), BW'(1));
    skip_band = -1;

    // 4: prescaler=0 with tick every cycle, slow calculator -> overrun
    do_reset();
    calc_lat = 5;
    push_seq();
    sample_tick = 1'b1;
    trig_cyc = cyc_n;
    cyc(10);
    sample_tick = 1'b0;
    chk("t4_overrun", BW'(overrun), BW'(1));
    chk("t4_busy", BW'(busy), BW'(1));
    cyc(70);
    frame(1'b1, mk_bins(0, -1));
    calc_lat = 1;

    // 5: reset while waiting on band 6
    push_seq(7);
    tick();
    cyc(13);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("t5_busy", BW'(busy), '0);
    chk("t5_bins", bins_out, '0);
    chk("t5_overrun", BW'(overrun), '0);
    chk("t5_calc_band", BW'(calc_band), '0);
    chk("t5_calc_start", BW'(calc_start), '0);
    chk("t5_bands_before_reset", BW'(exp_band_q.size()), '0);
    cyc(3);
    push_seq();
    tick();
    cyc(25);
    chk("t5_restart_latency", BW'(start_cyc[0]), BW'(trig_cyc + 1));
    frame(1'b1, mk_bins(0, -1));

    // 6: frame_start coincident with last calc_done is ignored
    voff = 5;
    push_seq();
    tick();
    cyc(19);
    frame(1'b0, '0);
    cyc(3);
    chk("t6_bins_hold", bins_out, mk_bins(0, -1));
    chk("t6_busy_pend", BW'(busy), BW'(1));
    frame(1'b1, mk_bins(5, -1));

    cyc(3);
    chk("pending_bands", BW'(exp_band_q.size()), '0);
    chk("pending_commits", BW'(exp_bins_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
